// File: rtl/miner_pkg.sv
// Shared types for the miner top level.
//   miner_status_t : externally visible dispatcher status code
//   disp_state_t   : internal nonce_dispatcher FSM state
//   NONCE_W_DEFAULT: default nonce width
package miner_pkg;

  localparam int unsigned NONCE_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_EXHAUSTED = 2'd2,
    ST_FOUND     = 2'd3
  } miner_status_t;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_RUN,
    DS_DRAIN,
    DS_FOUND,
    DS_EXHAUSTED
  } disp_state_t;

  function automatic miner_status_t status_of(input disp_state_t s);
    miner_status_t r;
    case (s)
      DS_RUN, DS_DRAIN: r = ST_RUN;
      DS_FOUND:         r = ST_FOUND;
      DS_EXHAUSTED:     r = ST_EXHAUSTED;
      default:          r = ST_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_mask : candidate cores (1 = eligible)
//   ptr      : index where the search starts
//   grant    : one-hot first eligible core at or after ptr (cyclic)
//   any      : at least one core eligible
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 any
);

  always_comb begin
    int unsigned idx;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!any && req_mask[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Hands out contiguous nonce chunks to NUM_CORES hash cores in ascending
// order, collects hit reports and keeps the lowest winning nonce.
//   clk, rst        : clock, async active-high reset
//   start, abort    : control pulses from the register block
//   core_req        : one-hot job offer (registered)
//   job_nonce       : base nonce of the offered job (registered)
//   core_ack        : core accepts the offered job
//   core_done       : core finished its job; core_hit qualifies a hit
//   core_hit_nonce  : flat bus of per-core winning nonces
//   core_abort      : broadcast job cancel pulse
//   status          : 0 idle, 1 running, 2 exhausted, 3 found
//   found_nonce     : lowest winning nonce
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NONCE_W   = NONCE_W_DEFAULT,
  parameter int unsigned CHUNK_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  output logic [NUM_CORES-1:0]           core_req,
  output logic [NONCE_W-1:0]             job_nonce,
  input  logic [NUM_CORES-1:0]           core_ack,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_hit,
  input  logic [NUM_CORES*NONCE_W-1:0]   core_hit_nonce,
  output logic                           core_abort,
  output logic [1:0]                     status,
  output logic [NONCE_W-1:0]             found_nonce
);

  localparam int unsigned        PTR_W      = $clog2(NUM_CORES);
  localparam logic [NONCE_W-1:0] ONE        = NONCE_W'(1);
  localparam logic [NONCE_W-1:0] CHUNK_STEP = ONE << CHUNK_W;
  localparam logic [NONCE_W-1:0] LAST_BASE  = ~(CHUNK_STEP - ONE);

  disp_state_t          state, state_nxt;
  logic [NUM_CORES-1:0] outstanding, outstanding_nxt;
  logic [NONCE_W-1:0]   next_nonce, next_nonce_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic                 hit_valid, hit_valid_nxt;
  logic                 last_issued, last_issued_nxt;
  logic [NONCE_W-1:0]   found_nonce_nxt;
  logic [NUM_CORES-1:0] core_req_nxt;
  logic [NONCE_W-1:0]   job_nonce_nxt;
  logic                 core_abort_nxt;

  logic [NUM_CORES-1:0] ack_valid;
  logic [NUM_CORES-1:0] done_valid;
  logic [NUM_CORES-1:0] hit_bits;
  logic [PTR_W-1:0]     ack_ptr;
  logic                 hit_any;
  logic [NONCE_W-1:0]   hit_min;
  logic [NUM_CORES-1:0] free_mask;
  logic [NUM_CORES-1:0] arb_grant;
  logic                 arb_any;

  // Acks only count against a live offer; dones only for jobs we handed out.
  assign ack_valid  = core_ack & core_req;
  assign done_valid = core_done & outstanding;
  assign hit_bits   = done_valid & core_hit;
  assign free_mask  = ~outstanding_nxt;

  // Pointer advances to the core after the one holding the offer.
  always_comb begin
    ack_ptr = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (core_req[i]) ack_ptr = PTR_W'((i + 1) % NUM_CORES);
    end
  end

  // Minimum over all same-cycle hits.
  always_comb begin
    hit_any = 1'b0;
    hit_min = '1;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hit_bits[i] && (!hit_any || core_hit_nonce[i*NONCE_W +: NONCE_W] < hit_min)) begin
        hit_min = core_hit_nonce[i*NONCE_W +: NONCE_W];
        hit_any = 1'b1;
      end
    end
  end

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req_mask (free_mask),
    .ptr      (ptr_nxt),
    .grant    (arb_grant),
    .any      (arb_any)
  );

  always_comb begin
    state_nxt       = state;
    outstanding_nxt = outstanding;
    next_nonce_nxt  = next_nonce;
    ptr_nxt         = ptr;
    hit_valid_nxt   = hit_valid;
    last_issued_nxt = last_issued;
    found_nonce_nxt = found_nonce;
    core_abort_nxt  = 1'b0;

    case (state)
      DS_IDLE, DS_FOUND, DS_EXHAUSTED: begin
        if (start && !abort) begin
          state_nxt       = DS_RUN;
          outstanding_nxt = '0;
          next_nonce_nxt  = '0;
          found_nonce_nxt = '0;
          ptr_nxt         = '0;
          hit_valid_nxt   = 1'b0;
          last_issued_nxt = 1'b0;
        end
      end
      DS_RUN, DS_DRAIN: begin
        if (abort) begin
          core_abort_nxt  = 1'b1;
          outstanding_nxt = '0;
          state_nxt       = DS_IDLE;
        end else begin
          outstanding_nxt = (outstanding & ~done_valid) | ack_valid;
          if (|ack_valid) begin
            next_nonce_nxt = next_nonce + CHUNK_STEP;
            ptr_nxt        = ack_ptr;
            if (job_nonce == LAST_BASE) begin
              last_issued_nxt = 1'b1;
              state_nxt       = DS_DRAIN;
            end
          end
          if (hit_any) begin
            hit_valid_nxt = 1'b1;
            if (!hit_valid || hit_min < found_nonce) found_nonce_nxt = hit_min;
            state_nxt = DS_DRAIN;
          end
          // DRAIN is only entered on a hit or on wrap, so no hit means wrap.
          if (state == DS_DRAIN && outstanding == '0) begin
            state_nxt = hit_valid ? DS_FOUND : DS_EXHAUSTED;
          end
        end
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

  // Offer register: an unacked offer is held; otherwise a fresh pick is made
  // from the post-update mask/pointer so an ack yields the next offer at once.
  always_comb begin
    core_req_nxt  = '0;
    job_nonce_nxt = next_nonce_nxt;
    if (state == DS_RUN && state_nxt == DS_RUN) begin
      if (core_req != '0 && ack_valid == '0) begin
        core_req_nxt = core_req;
      end else if (arb_any) begin
        core_req_nxt = arb_grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DS_IDLE;
      outstanding <= '0;
      next_nonce  <= '0;
      ptr         <= '0;
      hit_valid   <= 1'b0;
      last_issued <= 1'b0;
      found_nonce <= '0;
      core_req    <= '0;
      job_nonce   <= '0;
      core_abort  <= 1'b0;
      status      <= ST_IDLE;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      next_nonce  <= next_nonce_nxt;
      ptr         <= ptr_nxt;
      hit_valid   <= hit_valid_nxt;
      last_issued <= last_issued_nxt;
      found_nonce <= found_nonce_nxt;
      core_req    <= core_req_nxt;
      job_nonce   <= job_nonce_nxt;
      core_abort  <= core_abort_nxt;
      status      <= status_of(state_nxt);
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
module tb_nonce_dispatcher;

  logic         clk;
  logic         rst;
  logic         start, abort;
  logic [3:0]   core_req, core_ack, core_done, core_hit;
  logic [31:0]  job_nonce, found_nonce;
  logic [127:0] core_hit_nonce;
  logic         core_abort;
  logic [1:0]   status;

  logic         s_start, s_abort;
  logic [3:0]   s_req, s_ack, s_done, s_hit;
  logic [11:0]  s_job, s_found;
  logic [47:0]  s_hit_nonce;
  logic         s_core_abort;
  logic [1:0]   s_status;

  int checks = 0;
  int errors = 0;

  nonce_dispatcher #(.NUM_CORES(4), .NONCE_W(32), .CHUNK_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .core_req(core_req), .job_nonce(job_nonce), .core_ack(core_ack),
    .core_done(core_done), .core_hit(core_hit), .core_hit_nonce(core_hit_nonce),
    .core_abort(core_abort), .status(status), .found_nonce(found_nonce)
  );

  nonce_dispatcher #(.NUM_CORES(4), .NONCE_W(12), .CHUNK_W(8)) dut12 (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .core_req(s_req), .job_nonce(s_job), .core_ack(s_ack),
    .core_done(s_done), .core_hit(s_hit), .core_hit_nonce(s_hit_nonce),
    .core_abort(s_core_abort), .status(s_status), .found_nonce(s_found)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; core_ack = '0; core_done = '0; core_hit = '0;
    core_hit_nonce = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    s_start = 0; s_abort = 0; s_ack = '0; s_done = '0; s_hit = '0; s_hit_nonce = '0;
    tick(); tick();
    checks++; if (core_req !== 4'b0) begin errors++; $display("FAIL reset_core_req: got %b expected 0000", core_req); end
    checks++; if (job_nonce !== 32'h0) begin errors++; $display("FAIL reset_job_nonce: got %h expected 0", job_nonce); end
    checks++; if (core_abort !== 1'b0) begin errors++; $display("FAIL reset_core_abort: got %b expected 0", core_abort); end
    checks++; if (status !== 2'd0) begin errors++; $display("FAIL reset_status: got %0d expected 0", status); end
    checks++; if (found_nonce !== 32'h0) begin errors++; $display("FAIL reset_found: got %h expected 0", found_nonce); end
    checks++; if (s_status !== 2'd0) begin errors++; $display("FAIL reset_status12: got %0d expected 0", s_status); end
    rst = 1'b0;
    tick();
  endtask

  // Start pulse; afterwards the first offer is one edge away.
  task automatic do_start(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (status !== 2'd1) begin errors++; $display("FAIL %s_start_status: got %0d expected 1", name, status); end
    checks++; if (core_req !== 4'b0) begin errors++; $display("FAIL %s_start_req: got %b expected 0000", name, core_req); end
    checks++; if (found_nonce !== 32'h0) begin errors++; $display("FAIL %s_start_found: got %h expected 0", name, found_nonce); end
  endtask

  // Cores ack immediately: offers go to cores 0..3 with bases 0x000..0x300.
  task automatic issue_jobs(input string name, input int n);
    logic [3:0]  exp_req;
    logic [31:0] exp_nonce;
    tick();
    for (int i = 0; i < n; i++) begin
      exp_req   = 4'b0001 << i;
      exp_nonce = 32'(i * 256);
      checks++; if (core_req !== exp_req) begin errors++; $display("FAIL %s_req%0d: got %b expected %b", name, i, core_req, exp_req); end
      checks++; if (job_nonce !== exp_nonce) begin errors++; $display("FAIL %s_nonce%0d: got %h expected %h", name, i, job_nonce, exp_nonce); end
      core_ack = exp_req;
      tick();
      core_ack = '0;
    end
  endtask

  task automatic test_issue_order();
    do_start("order");
    issue_jobs("order", 4);
    checks++; if (core_req !== 4'b0) begin errors++; $display("FAIL order_all_busy: got %b expected 0000", core_req); end
    core_done = 4'b0010;
    tick();
    core_done = '0;
    checks++; if (core_req !== 4'b0010) begin errors++; $display("FAIL order_refill_req: got %b expected 0010", core_req); end
    checks++; if (job_nonce !== 32'h400) begin errors++; $display("FAIL order_refill_nonce: got %h expected 400", job_nonce); end
    core_ack = 4'b0010; core_done = 4'b0100;
    tick();
    core_ack = '0; core_done = '0;
    checks++; if (core_req !== 4'b0100) begin errors++; $display("FAIL order_ackdone_req: got %b expected 0100", core_req); end
    checks++; if (job_nonce !== 32'h500) begin errors++; $display("FAIL order_ackdone_nonce: got %h expected 500", job_nonce); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (status !== 2'd0) begin errors++; $display("FAIL order_abort_status: got %0d expected 0", status); end
    tick();
  endtask

  task automatic test_single_hit();
    do_start("single");
    issue_jobs("single", 4);
    core_done = 4'b0010; core_hit = 4'b0010; core_hit_nonce[32 +: 32] = 32'h142;
    tick();
    clear_inputs();
    checks++; if (core_req !== 4'b0) begin errors++; $display("FAIL single_no_offer: got %b expected 0000", core_req); end
    checks++; if (status !== 2'd1) begin errors++; $display("FAIL single_drain_status: got %0d expected 1", status); end
    core_done = 4'b0001;
    tick();
    core_done = 4'b1100;
    tick();
    core_done = '0;
    checks++; if (core_req !== 4'b0) begin errors++; $display("FAIL single_no_offer2: got %b expected 0000", core_req); end
    checks++; if (status !== 2'd1) begin errors++; $display("FAIL single_last_done_status: got %0d expected 1", status); end
    tick();
    checks++; if (status !== 2'd3) begin errors++; $display("FAIL single_status: got %0d expected 3", status); end
    checks++; if (found_nonce !== 32'h142) begin errors++; $display("FAIL single_found: got %h expected 142", found_nonce); end
  endtask

  task automatic test_late_lower_hit();
    do_start("late");
    issue_jobs("late", 4);
    core_done = 4'b0100; core_hit = 4'b0100; core_hit_nonce[64 +: 32] = 32'h2A0;
    tick();
    clear_inputs();
    core_done = 4'b0001; core_hit = 4'b0001; core_hit_nonce[0 +: 32] = 32'h02A;
    tick();
    clear_inputs();
    core_done = 4'b1010;
    tick();
    core_done = '0;
    tick();
    checks++; if (status !== 2'd3) begin errors++; $display("FAIL late_status: got %0d expected 3", status); end
    checks++; if (found_nonce !== 32'h02A) begin errors++; $display("FAIL late_found: got %h expected 02a", found_nonce); end
  endtask

  task automatic test_same_cycle_hits();
    do_start("same");
    issue_jobs("same", 4);
    core_done = 4'b1010; core_hit = 4'b1010;
    core_hit_nonce[32 +: 32] = 32'h150; core_hit_nonce[96 +: 32] = 32'h310;
    tick();
    clear_inputs();
    core_done = 4'b0101;
    tick();
    core_done = '0;
    tick();
    checks++; if (status !== 2'd3) begin errors++; $display("FAIL same_status: got %0d expected 3", status); end
    checks++; if (found_nonce !== 32'h150) begin errors++; $display("FAIL same_found: got %h expected 150", found_nonce); end
  endtask

  // A hit while an offer is pending withdraws it; a late ack must be ignored.
  task automatic test_hit_withdraw();
    do_start("withdraw");
    issue_jobs("withdraw", 2);
    checks++; if (core_req !== 4'b0100) begin errors++; $display("FAIL withdraw_pending: got %b expected 0100", core_req); end
    core_done = 4'b0001; core_hit = 4'b0001; core_hit_nonce[0 +: 32] = 32'h005;
    tick();
    clear_inputs();
    checks++; if (core_req !== 4'b0) begin errors++; $display("FAIL withdraw_req: got %b expected 0000", core_req); end
    core_ack = 4'b0100;
    tick();
    core_ack = '0;
    core_done = 4'b0010;
    tick();
    core_done = '0;
    checks++; if (status !== 2'd1) begin errors++; $display("FAIL withdraw_drain: got %0d expected 1", status); end
    tick();
    checks++; if (status !== 2'd3) begin errors++; $display("FAIL withdraw_status: got %0d expected 3", status); end
    checks++; if (found_nonce !== 32'h005) begin errors++; $display("FAIL withdraw_found: got %h expected 005", found_nonce); end
  endtask

  task automatic test_abort_restart();
    do_start("abort");
    issue_jobs("abort", 3);
    checks++; if (core_req !== 4'b1000) begin errors++; $display("FAIL abort_pending: got %b expected 1000", core_req); end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checks++; if (core_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", core_abort); end
    checks++; if (status !== 2'd0) begin errors++; $display("FAIL abort_status: got %0d expected 0", status); end
    checks++; if (core_req !== 4'b0) begin errors++; $display("FAIL abort_req: got %b expected 0000", core_req); end
    tick();
    checks++; if (core_abort !== 1'b0) begin errors++; $display("FAIL abort_pulse_end: got %b expected 0", core_abort); end
    checks++; if (status !== 2'd0) begin errors++; $display("FAIL abort_idle: got %0d expected 0", status); end
    do_start("restart");
    tick();
    checks++; if (core_req !== 4'b0001) begin errors++; $display("FAIL restart_req: got %b expected 0001", core_req); end
    checks++; if (job_nonce !== 32'h0) begin errors++; $display("FAIL restart_nonce: got %h expected 0", job_nonce); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // 12-bit nonce space: 16 chunks, each core completes one cycle after acking.
  task automatic test_exhaustion();
    logic [3:0]  exp_req;
    logic [11:0] exp_nonce;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      exp_req   = 4'b0001 << (k % 4);
      exp_nonce = 12'(k * 256);
      checks++; if (s_req !== exp_req) begin errors++; $display("FAIL exh_req%0d: got %b expected %b", k, s_req, exp_req); end
      checks++; if (s_job !== exp_nonce) begin errors++; $display("FAIL exh_nonce%0d: got %h expected %h", k, s_job, exp_nonce); end
      s_ack  = exp_req;
      s_done = (k > 0) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
      tick();
    end
    s_ack = '0;
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL exh_no_more: got %b expected 0000", s_req); end
    s_done = 4'b1000;
    tick();
    s_done = '0;
    checks++; if (s_status !== 2'd1) begin errors++; $display("FAIL exh_drain: got %0d expected 1", s_status); end
    tick();
    checks++; if (s_status !== 2'd2) begin errors++; $display("FAIL exh_status: got %0d expected 2", s_status); end
    checks++; if (s_found !== 12'h0) begin errors++; $display("FAIL exh_found: got %h expected 0", s_found); end
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL exh_req_end: got %b expected 0000", s_req); end
  endtask

  initial begin
    test_reset();
    test_issue_order();
    test_single_hit();
    test_late_lower_hit();
    test_same_cycle_hits();
    test_hit_withdraw();
    test_abort_restart();
    test_exhaustion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonce_dispatcher.md
# nonce_dispatcher

Schedules nonce-search jobs across `NUM_CORES` parallel double-SHA-256 hash cores inside the miner top level. It sits between the slave-register control logic (start/abort, status and nonce readback) and the core array. Each idle core receives a contiguous chunk of nonces under round-robin arbitration. The dispatcher collects hit reports and returns the lowest winning nonce, so the result is the same regardless of core timing.

## Interface
- `NUM_CORES`, 4: number of hash cores, 2..8.
- `NONCE_W`, 32: nonce width.
- `CHUNK_W`, 8: log2 of nonces per job, 0 < `CHUNK_W` < `NONCE_W`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: one-cycle pulse; begins a new search from nonce 0.
- `abort` in 1: one-cycle pulse; cancels the current search.
- `core_req` out `NUM_CORES`: one-hot job offer to core i.
- `job_nonce` out `NONCE_W`: base nonce of the offered job, shared by all cores.
- `core_ack` in `NUM_CORES`: core i accepts the job; only valid while `core_req[i]` is high.
- `core_done` in `NUM_CORES`: one-cycle pulse; core i finished its job.
- `core_hit` in `NUM_CORES`: qualified by `core_done[i]`; core i found a hash ≤ target.
- `core_hit_nonce` in `NUM_CORES*NONCE_W`: flat bus, slice i is the winning nonce of core i.
- `core_abort` out 1: one-cycle broadcast; cores drop their current job.
- `status` out 2: 0 idle, 1 running, 2 exhausted, 3 found.
- `found_nonce` out `NONCE_W`: lowest winning nonce; valid when `status`==3.

## Operation
- States:
  - IDLE: `status` 0.
  - RUN: `status` 1; issuing jobs.
  - DRAIN: `status` 1; no new issue, waiting for outstanding jobs.
  - FOUND: `status` 3.
  - EXHAUSTED: `status` 2.
- `start` in IDLE, FOUND or EXHAUSTED:
  - clears `next_nonce`, `found_nonce`, the outstanding mask and the hit-valid flag;
  - sets the round-robin pointer to core 0;
  - moves to RUN.
- `start` in RUN or DRAIN is ignored.
- Issue (RUN only):
  - rr_arbiter picks the first non-outstanding core at or after the pointer.
  - `core_req` is one-hot to that core and `job_nonce` = `next_nonce`; both hold until `core_ack`.
- On ack:
  - the core is marked outstanding;
  - `next_nonce` += 2^`CHUNK_W`;
  - the pointer moves to the core after the acked one.
- Wrap: if the ack'd base is 2^`NONCE_W` − 2^`CHUNK_W`, set `last_issued` and go to DRAIN.
- Completion: `core_done[i]` clears outstanding bit i. A `core_done` for a non-outstanding core is ignored.
- Hit handling:
  - Any hit compares `core_hit_nonce[i]` with `found_nonce`; the minimum is kept, and any hit beats an empty result.
  - Multiple hits in the same cycle are reduced to their minimum.
  - The first hit moves RUN to DRAIN and drops `core_req` the next cycle. An offer not yet ack'd is withdrawn.
- DRAIN exit, when the outstanding mask is zero:
  - a hit was recorded → FOUND;
  - otherwise `last_issued` is set → EXHAUSTED.
- Jobs are issued in ascending nonce order and all issued jobs drain before the result is reported. The reported nonce is therefore the global minimum up to the last issued chunk.
- `abort` in RUN or DRAIN:
  - `core_abort` pulses;
  - the outstanding mask clears and `core_req` goes to 0;
  - next state is IDLE.
- `abort` in other states is ignored.
- `abort` and `start` in the same cycle: `abort` wins.
- Reset mid-operation: all state is discarded and no `core_abort` is emitted; `rst` resets the cores directly.

## Timing
- Reset values: `core_req`=0, `job_nonce`=0, `core_abort`=0, `status`=0, `found_nonce`=0, state IDLE.
- `start` at edge t: RUN and `core_req` valid after edge t+1.
- Issue rate: one job per cycle max. `core_ack` in cycle c presents the next offer in cycle c+1.
- `core_done` and `core_ack` in the same cycle on different cores are both honoured.
- A hit in cycle c: no new ack is accepted from cycle c+1.
- The last outstanding `core_done` at edge t gives `status` 3 or 2 after edge t+1.
- All outputs are registered.

## Structure
- `miner_pkg`: `miner_status_t` enum (IDLE=0, RUN=1, EXHAUSTED=2, FOUND=3), dispatcher state enum, `NONCE_W` default.
- Sub-module `rr_arbiter` (parameter N; inputs `req_mask`, `ptr`; outputs one-hot `grant` and `any`) is purely combinational.
- The dispatcher owns the FSM, `next_nonce`, the outstanding mask and the min-reduction tree.

## Test plan
All scenarios use `NUM_CORES`=4 and `CHUNK_W`=8 except where stated.
- **Issue order:** `start` with cores acking immediately → `job_nonce` 0x000, 0x100, 0x200, 0x300 to cores 0–3 on consecutive cycles, then no `core_req`.
- **Single hit:** core 1 hits 0x142; cores 0, 2, 3 then finish without a hit → no further offers, `status`=3, `found_nonce`=0x142.
- **Late lower hit:** core 2 hits 0x2A0, then core 0 hits 0x02A → `found_nonce`=0x02A (42).
- **Same-cycle hits:** core 1 hits 0x150 and core 3 hits 0x310 in one cycle → `found_nonce`=0x150.
- **Abort and restart:** `abort` with 3 jobs outstanding → `core_abort` pulse, `status`=0 next cycle; re-`start` → first `job_nonce`=0x000.
- **Exhaustion:** `NONCE_W`=12, no hits → exactly 16 jobs (last base 0xF00), then `status`=2 and `found_nonce`=0.
